// File: rtl/seq_cmp.sv
// Multi-cycle WIDTH-bit magnitude comparator (eq/lt/gt, signed or unsigned), BPC bits per clock, MSB chunk first.
// Define SEQ_CMP_EARLY_EXIT_EN to finish on the first differing chunk instead of always taking N cycles.
module seq_cmp #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_md,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0]    cnt;
  logic             dlt, dgt;

  logic             accept;
  logic [BPC-1:0]   chunk_a, chunk_b;
  logic             undecided;
  logic             dlt_nxt, dgt_nxt;
  logic             last;
  logic             finish;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Chunk decision: the operand registers shift left, so the chunk under test is always at the top
  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    chunk_a   = a_r[WIDTH-1 -: BPC];
    chunk_b   = b_r[WIDTH-1 -: BPC];
    undecided = ~(dlt | dgt);
    dlt_nxt   = dlt | (undecided & (chunk_a < chunk_b));
    dgt_nxt   = dgt | (undecided & (chunk_a > chunk_b));
    last      = (cnt == LAST);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    finish    = last | dlt_nxt | dgt_nxt;
`else
    finish    = last;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: flipping both MSBs in signed mode turns the signed compare into an unsigned one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      cnt <= '0;
      dlt <= 1'b0;
      dgt <= 1'b0;
      eq  <= 1'b0;
      lt  <= 1'b0;
      gt  <= 1'b0;
    end else if (accept) begin
      a_r <= a ^ (signed_md ? MSB : '0);
      b_r <= b ^ (signed_md ? MSB : '0);
      cnt <= '0;
      dlt <= 1'b0;
      dgt <= 1'b0;
    end else if (state == RUN) begin
      a_r <= a_r << BPC;
      b_r <= b_r << BPC;
      cnt <= cnt + 1'b1;
      dlt <= dlt_nxt;
      dgt <= dgt_nxt;
      if (finish) begin
        eq <= ~(dlt_nxt | dgt_nxt);
        lt <= dlt_nxt;
        gt <= dgt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_cmp.sv
// Scoreboard bench for seq_cmp: an 8-bit/1-bit-per-cycle instance and a 16-bit/4-bit-per-cycle instance.
module tb_seq_cmp;

  typedef struct {
    logic eq;
    logic lt;
    logic gt;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0, sm8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, eq8, lt8, gt8;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, eq16, lt16, gt16;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  seq_cmp #(.WIDTH(8), .BPC(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_md(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .eq(eq8), .lt(lt8), .gt(gt8)
  );

  seq_cmp #(.WIDTH(16), .BPC(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_md(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .eq(eq16), .lt(lt16), .gt(gt16)
  );

  function automatic logic get_done(input int sel);
    return (sel != 0) ? done16 : done8;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy16 : busy8;
  endfunction

  function automatic logic [2:0] get_res(input int sel);
    return (sel != 0) ? {eq16, lt16, gt16} : {eq8, lt8, gt8};
  endfunction

  // Reference: integer compare of sign- or zero-extended operands; latency from first differing chunk
  function automatic exp_t model(input int sel, input logic [15:0] a, input logic [15:0] b, input logic sm);
    exp_t e;
    int w, bpc, n, av, bv;
    logic [15:0] ca, cb, m;
    w   = (sel != 0) ? 16 : 8;
    bpc = (sel != 0) ? 4 : 1;
    n   = w / bpc;
    if (w == 8) begin
      av = sm ? {{24{a[7]}}, a[7:0]} : {24'd0, a[7:0]};
      bv = sm ? {{24{b[7]}}, b[7:0]} : {24'd0, b[7:0]};
    end else begin
      av = sm ? {{16{a[15]}}, a} : {16'd0, a};
      bv = sm ? {{16{b[15]}}, b} : {16'd0, b};
    end
    e.eq  = (av == bv);
    e.lt  = (av < bv);
    e.gt  = (av > bv);
    e.lat = n;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    m = (16'd1 << bpc) - 16'd1;
    for (int c = 0; c < n; c++) begin
      ca = (a >> (w - (c + 1) * bpc)) & m;
      cb = (b >> (w - (c + 1) * bpc)) & m;
      if (ca != cb) begin
        e.lat = c + 1;
        break;
      end
    end
`endif
    return e;
  endfunction

  task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b, input logic sm, input logic st);
    if (sel != 0) begin
      a16 = a; b16 = b; sm16 = sm; start16 = st;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; start8 = st;
    end
  endtask

  task automatic set_start(input int sel, input logic st);
    if (sel != 0) start16 = st;
    else start8 = st;
  endtask

  // k = number of edges after the start edge at which done is seen; bc = cycles with busy high
  task automatic wait_done(input int sel, output int k, output int bc);
    k = 0;
    bc = 0;
    while (!get_done(sel) && k < 200) begin
      if (get_busy(sel)) bc++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic sm, input string name);
    exp_t e;
    int k, bc;
    logic [2:0] r;
    @(negedge clk);
    drive(sel, a, b, sm, 1'b1);
    sbq.push_back(model(sel, a, b, sm));
    @(negedge clk);
    set_start(sel, 1'b0);
    wait_done(sel, k, bc);
    e = sbq.pop_front();
    checks++;
    if (k >= 200) begin
      $display("FAIL %s timeout: no done within %0d cycles", name, k);
      errors++;
      return;
    end
    if (k !== e.lat) begin
      $display("FAIL %s latency: got %0d expected %0d", name, k, e.lat);
      errors++;
    end
    checks++;
    r = get_res(sel);
    if (r !== {e.eq, e.lt, e.gt}) begin
      $display("FAIL %s result eq/lt/gt: got %b expected %b", name, r, {e.eq, e.lt, e.gt});
      errors++;
    end
    checks++;
    if (bc !== e.lat) begin
      $display("FAIL %s busy cycles: got %0d expected %0d", name, bc, e.lat);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (get_done(sel) !== 1'b0) begin
      $display("FAIL %s done pulse width: got done=%b expected 0", name, get_done(sel));
      errors++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy8, done8, eq8, lt8, gt8} !== 5'b0) begin
      $display("FAIL reset8 busy/done/eq/lt/gt: got %b expected 00000", {busy8, done8, eq8, lt8, gt8});
      errors++;
    end
    checks++;
    if ({busy16, done16, eq16, lt16, gt16} !== 5'b0) begin
      $display("FAIL reset16 busy/done/eq/lt/gt: got %b expected 00000", {busy16, done16, eq16, lt16, gt16});
      errors++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    run_op(0, 16'h5A, 16'h5A, 1'b0, "u_eq_5a");
    run_op(0, 16'h80, 16'h7F, 1'b0, "u_80_7f");
    run_op(0, 16'hFF, 16'h00, 1'b0, "u_ff_00");
    run_op(0, 16'h00, 16'hFF, 1'b0, "u_00_ff");
  endtask

  task automatic test_signed;
    run_op(0, 16'h80, 16'h7F, 1'b1, "s_80_7f");
    run_op(0, 16'hFF, 16'h00, 1'b1, "s_ff_00");
    run_op(0, 16'h7F, 16'h80, 1'b1, "s_7f_80");
    run_op(0, 16'h80, 16'h81, 1'b1, "s_80_81");
    run_op(0, 16'hFF, 16'hFF, 1'b1, "s_ff_ff");
  endtask

  task automatic test_early_exit;
    run_op(0, 16'h80, 16'h00, 1'b0, "ee_80_00");
    run_op(0, 16'h01, 16'h00, 1'b0, "ee_01_00");
    run_op(1, 16'h8000, 16'h7FFF, 1'b1, "ee16_s_8000_7fff");
  endtask

  task automatic test_wide;
    exp_t e;
    int k;
    logic extra;
    @(negedge clk);
    drive(1, 16'h1234, 16'h1235, 1'b0, 1'b1);
    sbq.push_back(model(1, 16'h1234, 16'h1235, 1'b0));
    @(negedge clk);
    start16 = 1'b0;
    k = 0;
    while (!done16 && k < 200) begin
      if (k == 1) drive(1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
      if (k == 2) start16 = 1'b0;
      @(negedge clk);
      k++;
    end
    e = sbq.pop_front();
    checks++;
    if (k !== e.lat) begin
      $display("FAIL wide_ignore latency: got %0d expected %0d", k, e.lat);
      errors++;
    end
    checks++;
    if ({eq16, lt16, gt16} !== {e.eq, e.lt, e.gt}) begin
      $display("FAIL wide_ignore result eq/lt/gt: got %b expected %b", {eq16, lt16, gt16}, {e.eq, e.lt, e.gt});
      errors++;
    end
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done16 || busy16) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      $display("FAIL wide_ignore extra activity: got %b expected 0", extra);
      errors++;
    end
    run_op(1, 16'hFFFF, 16'h0000, 1'b1, "w16_s_ffff_0000");
    run_op(1, 16'hFFFF, 16'h0000, 1'b0, "w16_u_ffff_0000");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int k, bc;
    logic held_bad;
    @(negedge clk);
    drive(0, 16'h40, 16'h10, 1'b0, 1'b1);
    sbq.push_back(model(0, 16'h40, 16'h10, 1'b0));
    @(negedge clk);
    start8 = 1'b0;
    wait_done(0, k, bc);
    e = sbq.pop_front();
    checks++;
    if ({eq8, lt8, gt8} !== {e.eq, e.lt, e.gt} || k !== e.lat) begin
      $display("FAIL b2b_first got res=%b lat=%0d expected res=%b lat=%0d", {eq8, lt8, gt8}, k, {e.eq, e.lt, e.gt}, e.lat);
      errors++;
    end
    drive(0, 16'h03, 16'h09, 1'b0, 1'b1);
    sbq.push_back(model(0, 16'h03, 16'h09, 1'b0));
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      $display("FAIL b2b_no_idle busy: got %b expected 1", busy8);
      errors++;
    end
    k = 0;
    held_bad = 1'b0;
    while (!done8 && k < 200) begin
      if ({eq8, lt8, gt8} !== 3'b001) held_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    checks++;
    if (held_bad !== 1'b0) begin
      $display("FAIL b2b_hold previous result changed early: got %b expected 0", held_bad);
      errors++;
    end
    e = sbq.pop_front();
    checks++;
    if ({eq8, lt8, gt8} !== {e.eq, e.lt, e.gt} || k !== e.lat) begin
      $display("FAIL b2b_second got res=%b lat=%0d expected res=%b lat=%0d", {eq8, lt8, gt8}, k, {e.eq, e.lt, e.gt}, e.lat);
      errors++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    drive(0, 16'h55, 16'h55, 1'b0, 1'b1);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy8 !== 1'b1) begin
      $display("FAIL rst_mid busy before reset: got %b expected 1", busy8);
      errors++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, eq8, lt8, gt8} !== 5'b0) begin
      $display("FAIL rst_mid async clear: got %b expected 00000", {busy8, done8, eq8, lt8, gt8});
      errors++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      $display("FAIL rst_mid stray done/busy after abort: got %b expected 0", seen);
      errors++;
    end
    run_op(0, 16'h81, 16'h80, 1'b1, "rst_mid_after");
  endtask

  task automatic test_random;
    logic [15:0] ra, rb;
    logic rs;
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = (i % 3 == 0) ? ra : 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op(i % 2, ra, rb, rs, "random");
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_early_exit();
    test_wide();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
